// File: rtl/morse_pkg.sv
// Shared types, unit ratios and character encoding for the Morse playback block.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    MARK     = 3'd2,
    GAP      = 3'd3,
    CHAR_GAP = 3'd4,
    WORD_GAP = 3'd5
  } morse_state_e;

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] GAP_UNITS      = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd4;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    logic [7:0] r;
    if (c >= 8'h61 && c <= 8'h7A) r = c - 8'h20;
    else r = c;
    return r;
  endfunction

  // {supported, len[2:0], pattern[4:0]}; element i is pattern[4-i], 1 = dash.
  function automatic logic [8:0] morse_encode(input logic [7:0] ascii);
    logic [8:0] code;
    code = 9'b0;
    case (ascii)
      8'h41: code = {1'b1, 3'd2, 5'b01000};
      8'h42: code = {1'b1, 3'd4, 5'b10000};
      8'h43: code = {1'b1, 3'd4, 5'b10100};
      8'h44: code = {1'b1, 3'd3, 5'b10000};
      8'h45: code = {1'b1, 3'd1, 5'b00000};
      8'h46: code = {1'b1, 3'd4, 5'b00100};
      8'h47: code = {1'b1, 3'd3, 5'b11000};
      8'h48: code = {1'b1, 3'd4, 5'b00000};
      8'h49: code = {1'b1, 3'd2, 5'b00000};
      8'h4A: code = {1'b1, 3'd4, 5'b01110};
      8'h4B: code = {1'b1, 3'd3, 5'b10100};
      8'h4C: code = {1'b1, 3'd4, 5'b01000};
      8'h4D: code = {1'b1, 3'd2, 5'b11000};
      8'h4E: code = {1'b1, 3'd2, 5'b10000};
      8'h4F: code = {1'b1, 3'd3, 5'b11100};
      8'h50: code = {1'b1, 3'd4, 5'b01100};
      8'h51: code = {1'b1, 3'd4, 5'b11010};
      8'h52: code = {1'b1, 3'd3, 5'b01000};
      8'h53: code = {1'b1, 3'd3, 5'b00000};
      8'h54: code = {1'b1, 3'd1, 5'b10000};
      8'h55: code = {1'b1, 3'd3, 5'b00100};
      8'h56: code = {1'b1, 3'd4, 5'b00010};
      8'h57: code = {1'b1, 3'd3, 5'b01100};
      8'h58: code = {1'b1, 3'd4, 5'b10010};
      8'h59: code = {1'b1, 3'd4, 5'b10110};
      8'h5A: code = {1'b1, 3'd4, 5'b11000};
      8'h30: code = {1'b1, 3'd5, 5'b11111};
      8'h31: code = {1'b1, 3'd5, 5'b01111};
      8'h32: code = {1'b1, 3'd5, 5'b00111};
      8'h33: code = {1'b1, 3'd5, 5'b00011};
      8'h34: code = {1'b1, 3'd5, 5'b00001};
      8'h35: code = {1'b1, 3'd5, 5'b00000};
      8'h36: code = {1'b1, 3'd5, 5'b10000};
      8'h37: code = {1'b1, 3'd5, 5'b11000};
      8'h38: code = {1'b1, 3'd5, 5'b11100};
      8'h39: code = {1'b1, 3'd5, 5'b11110};
      default: code = 9'b0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_playback_ctrl_fifo.sv
// Character buffer: 8-bit synchronous FIFO with show-ahead read data.
module morse_char_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == CNT_W'(0));
  assign rdata = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    else wr_ptr_d = wr_ptr_q;
    if (do_pop_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    else rd_ptr_d = rd_ptr_q;
    if (do_push_s && !do_pop_s) count_d = count_q + CNT_W'(1);
    else if (do_pop_s && !do_push_s) count_d = count_q - CNT_W'(1);
    else count_d = count_q;
  end

  // Storage and pointer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/morse_playback_ctrl.sv
// Buffers ASCII characters and keys each one out as timed Morse code.
module morse_playback_ctrl
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12500000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_ascii,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        key_out,
  output logic [31:0] cur_ascii,
  output logic        busy,
  output logic        bad_char
);

  localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  morse_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       units_q, units_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       len_q, len_d;
  logic [4:0]       pat_q, pat_d;
  logic [7:0]       char_q, char_d;
  logic             sup_q, sup_d;
  logic             space_q, space_d;
  logic             bad_char_q, bad_char_d;
  logic             key_out_q, key_out_d;
  logic [31:0]      cur_ascii_q, cur_ascii_d;

  logic       fifo_full_s, fifo_empty_s, pop_s;
  logic [7:0] fifo_rdata_s, head_char_s;
  logic [8:0] head_code_s;
  logic       timed_s, unit_end_s, last_unit_s;

  morse_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop_s),
    .wdata (in_ascii),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign in_ready  = !fifo_full_s;
  assign busy      = (state_q != IDLE) || !fifo_empty_s;
  assign key_out   = key_out_q;
  assign cur_ascii = cur_ascii_q;
  assign bad_char  = bad_char_q;

  // Next-state, unit timer and output decode
  always_comb begin
    state_d     = state_q;
    units_d     = units_q;
    idx_d       = idx_q;
    len_d       = len_q;
    pat_d       = pat_q;
    char_d      = char_q;
    sup_d       = sup_q;
    space_d     = space_q;
    cur_ascii_d = cur_ascii_q;
    bad_char_d  = 1'b0;
    pop_s       = 1'b0;
    head_char_s = fold_case(fifo_rdata_s);
    head_code_s = morse_encode(head_char_s);
    timed_s     = (state_q != IDLE) && (state_q != LOAD);
    unit_end_s  = timed_s && (cnt_q == CNT_W'(UNIT_CYCLES - 1));
    last_unit_s = unit_end_s && (units_q == 3'd1);

    // The counter restarts at every state entry, so durations are exact unit multiples.
    if (!timed_s) cnt_d = '0;
    else if (unit_end_s) cnt_d = '0;
    else cnt_d = cnt_q + CNT_W'(1);

    if (unit_end_s && !last_unit_s) units_d = units_q - 3'd1;
    else units_d = units_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          char_d     = head_char_s;
          sup_d      = head_code_s[8];
          len_d      = head_code_s[7:5];
          pat_d      = head_code_s[4:0];
          space_d    = (head_char_s == 8'h20);
          bad_char_d = !head_code_s[8] && (head_char_s != 8'h20);
          state_d    = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (sup_q) begin
          cur_ascii_d = {24'h000000, char_q};
          idx_d       = 3'd0;
          units_d     = pat_q[4] ? DASH_UNITS : DOT_UNITS;
          state_d     = MARK;
        end else if (space_q) begin
          cur_ascii_d = 32'h0;
          units_d     = WORD_GAP_UNITS;
          state_d     = WORD_GAP;
        end else begin
          cur_ascii_d = 32'h0;
          state_d     = IDLE;
        end
      end
      MARK: begin
        if (last_unit_s) begin
          if ((idx_q + 3'd1) < len_q) begin
            units_d = GAP_UNITS;
            state_d = GAP;
          end else begin
            units_d = CHAR_GAP_UNITS;
            state_d = CHAR_GAP;
          end
        end else begin
          state_d = MARK;
        end
      end
      GAP: begin
        if (last_unit_s) begin
          idx_d   = idx_q + 3'd1;
          units_d = pat_q[3'd3 - idx_q] ? DASH_UNITS : DOT_UNITS;
          state_d = MARK;
        end else begin
          state_d = GAP;
        end
      end
      CHAR_GAP: begin
        if (last_unit_s) begin
          cur_ascii_d = 32'h0;
          state_d     = IDLE;
        end else begin
          state_d = CHAR_GAP;
        end
      end
      WORD_GAP: begin
        if (last_unit_s) state_d = IDLE;
        else state_d = WORD_GAP;
      end
      default: begin
        cur_ascii_d = 32'h0;
        state_d     = IDLE;
      end
    endcase

    key_out_d = (state_d == MARK);
  end

  // Controller state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      units_q     <= 3'd0;
      idx_q       <= 3'd0;
      len_q       <= 3'd0;
      pat_q       <= 5'd0;
      char_q      <= 8'h00;
      sup_q       <= 1'b0;
      space_q     <= 1'b0;
      bad_char_q  <= 1'b0;
      key_out_q   <= 1'b0;
      cur_ascii_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      units_q     <= units_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      pat_q       <= pat_d;
      char_q      <= char_d;
      sup_q       <= sup_d;
      space_q     <= space_d;
      bad_char_q  <= bad_char_d;
      key_out_q   <= key_out_d;
      cur_ascii_q <= cur_ascii_d;
    end
  end

endmodule

// File: tb/tb_morse_playback_ctrl.sv
// Directed bench for morse_playback_ctrl with UNIT_CYCLES=4, FIFO_DEPTH=4.
module tb_morse_playback_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_ascii = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        key_out;
  logic [31:0] cur_ascii;
  logic        busy;
  logic        bad_char;

  int checks = 0;
  int errors = 0;

  morse_playback_ctrl #(.UNIT_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_ascii  (in_ascii),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_out   (key_out),
    .cur_ascii (cur_ascii),
    .busy      (busy),
    .bad_char  (bad_char)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts on the first mark cycle; ends on the cycle after the character gap.
  task automatic expect_char(input string code, input logic [31:0] cur_exp);
    int n;
    for (int e = 0; e < code.len(); e++) begin
      n = (code[e] == 8'h2D) ? 12 : 4;
      for (int k = 0; k < n; k++) begin
        chk("mark_key", {31'b0, key_out}, 32'd1);
        chk("mark_cur", cur_ascii, cur_exp);
        tick();
      end
      if (e < code.len() - 1) begin
        for (int k = 0; k < 4; k++) begin
          chk("gap_key", {31'b0, key_out}, 32'd0);
          chk("gap_cur", cur_ascii, cur_exp);
          tick();
        end
      end
    end
    for (int k = 0; k < 12; k++) begin
      chk("chargap_key", {31'b0, key_out}, 32'd0);
      chk("chargap_cur", cur_ascii, cur_exp);
      tick();
    end
  endtask

  task automatic dead2();
    for (int k = 0; k < 2; k++) begin
      chk("dead_key", {31'b0, key_out}, 32'd0);
      chk("dead_cur", cur_ascii, 32'd0);
      chk("dead_busy", {31'b0, busy}, 32'd1);
      tick();
    end
  endtask

  task automatic push_one(input logic [7:0] ch);
    in_ascii = ch;
    in_valid = 1'b1;
    chk("push_busy0", {31'b0, busy}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("lat_busy1", {31'b0, busy}, 32'd1);
    chk("lat_key1", {31'b0, key_out}, 32'd0);
    tick();
    chk("lat_key2", {31'b0, key_out}, 32'd0);
    chk("lat_cur2", cur_ascii, 32'd0);
    tick();
  endtask

  task automatic expect_idle();
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_key", {31'b0, key_out}, 32'd0);
    chk("idle_cur", cur_ascii, 32'd0);
  endtask

  string s;
  int    idx;
  logic  rdy;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_key", {31'b0, key_out}, 32'd0);
    chk("rst_cur", cur_ascii, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_bad", {31'b0, bad_char}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;
    tick();

    // Single 'E' and lowercase 'a'
    push_one(8'h45);
    expect_char(".", 32'h45);
    expect_idle();
    tick();
    push_one(8'h61);
    expect_char(".-", 32'h41);
    expect_idle();
    tick();

    // "SOS" back to back
    in_valid = 1'b1;
    in_ascii = 8'h53; tick();
    in_ascii = 8'h4F; tick();
    in_ascii = 8'h53; tick();
    in_valid = 1'b0;
    expect_char("...", 32'h53);
    dead2();
    expect_char("---", 32'h4F);
    dead2();
    expect_char("...", 32'h53);
    expect_idle();
    tick();

    // Space is a 4-unit word gap
    in_ascii = 8'h20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      chk("word_busy", {31'b0, busy}, 32'd1);
      chk("word_key", {31'b0, key_out}, 32'd0);
      tick();
    end
    expect_idle();
    tick();

    // Fill the FIFO while '0' plays
    in_ascii = 8'h30;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    s = "ETIAN";
    idx = 0;
    for (int c = 2; c <= 92; c++) begin
      in_ascii = s[idx];
      in_valid = 1'b1;
      chk("fill_ready", {31'b0, in_ready}, (c < 6 || c >= 92) ? 32'd1 : 32'd0);
      if (c == 3) chk("fill_cur0", cur_ascii, 32'h30);
      rdy = in_ready;
      tick();
      if (rdy) idx++;
    end
    in_valid = 1'b0;
    chk("fill_accepted", idx, 32'd5);
    expect_char(".", 32'h45);
    dead2();
    expect_char("-", 32'h54);
    dead2();
    expect_char("..", 32'h49);
    dead2();
    expect_char(".-", 32'h41);
    dead2();
    expect_char("-.", 32'h4E);
    expect_idle();
    tick();

    // Unsupported '#' followed by '5'
    in_ascii = 8'h23;
    in_valid = 1'b1;
    tick();
    in_ascii = 8'h35;
    chk("bad_c1", {31'b0, bad_char}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bad_c2", {31'b0, bad_char}, 32'd1);
    chk("bad_key2", {31'b0, key_out}, 32'd0);
    tick();
    chk("bad_c3", {31'b0, bad_char}, 32'd0);
    chk("bad_key3", {31'b0, key_out}, 32'd0);
    chk("bad_cur3", cur_ascii, 32'd0);
    tick();
    chk("bad_c4", {31'b0, bad_char}, 32'd0);
    chk("bad_key4", {31'b0, key_out}, 32'd0);
    tick();
    expect_char(".....", 32'h35);
    expect_idle();
    tick();

    // Asynchronous reset during the second dash of '0', with 'E' still queued
    in_ascii = 8'h30;
    in_valid = 1'b1;
    tick();
    in_ascii = 8'h45;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("pre_rst_key", {31'b0, key_out}, 32'd1);
    chk("pre_rst_cur", cur_ascii, 32'h30);
    reset = 1'b1;
    #1;
    chk("arst_key", {31'b0, key_out}, 32'd0);
    chk("arst_cur", cur_ascii, 32'd0);
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      chk("post_rst_key", {31'b0, key_out}, 32'd0);
      chk("post_rst_busy", {31'b0, busy}, 32'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
